// File: rtl/ddr2_if_ex_pkg.sv
// Shared definitions for the DDR2 interface example blocks: pattern mode encodings.
package ddr2_if_ex_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_LFSR = 2'd0,
        MODE_WALK = 2'd1,
        MODE_ALT  = 2'd2,
        MODE_RSVD = 2'd3
    } pattern_mode_e;

endpackage

// File: rtl/ddr2_if_ex_pattern_step.sv
// Combinational next-pattern function shared by the generator and the checker.
module ddr2_if_ex_pattern_step
    import ddr2_if_ex_pkg::*;
#(
    parameter int unsigned         WIDTH = 8,
    parameter logic [WIDTH-1:0]    TAPS  = WIDTH'(8'h1C)
) (
    input  logic [WIDTH-1:0]  cur,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  nxt
);

    logic [WIDTH-1:0] rot_c;
    logic [WIDTH-1:0] fb_c;

    // Galois LFSR is a left rotate with the MSB folded into the tap positions; bit 0 tap is ignored.
    assign rot_c = {cur[WIDTH-2:0], cur[WIDTH-1]};
    assign fb_c  = {TAPS[WIDTH-1:1], 1'b0} & {WIDTH{cur[WIDTH-1]}};

    always_comb begin
        nxt = rot_c ^ fb_c;
        case (mode)
            MODE_WALK: nxt = rot_c;
            MODE_ALT:  nxt = ~cur;
            default:   nxt = rot_c ^ fb_c;
        endcase
    end

endmodule

// File: rtl/ddr2_if_ex_lfsr_genchk.sv
// Pattern generator (LFSR / walking-one / alternating) with a self-synchronised read-back checker.
module ddr2_if_ex_lfsr_genchk
    import ddr2_if_ex_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [63:0] TAPS  = 64'h1C,
    parameter logic [63:0] SEED  = 64'd32,
    parameter int unsigned CNTW  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               pause,
    input  logic               load,
    input  logic [WIDTH-1:0]   ldata,
    input  logic [MODE_W-1:0]  mode,
    output logic [WIDTH-1:0]   data,
    input  logic               chk_en,
    input  logic               chk_valid,
    input  logic [WIDTH-1:0]   chk_data,
    output logic               err_flag,
    output logic [CNTW-1:0]    err_cnt,
    output logic [CNTW-1:0]    first_err_idx
);

    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] TAPS_W = TAPS[WIDTH-1:0];

    logic [WIDTH-1:0] init_c;
    logic [WIDTH-1:0] gen_next_c;
    logic [WIDTH-1:0] chk_next_c;
    logic [WIDTH-1:0] expected;
    logic [CNTW-1:0]  vld_cnt;
    logic             mismatch_c;

    assign init_c     = (mode == MODE_WALK) ? WIDTH'(1) : SEED_W;
    assign mismatch_c = (chk_data != expected);

    ddr2_if_ex_pattern_step #(.WIDTH(WIDTH), .TAPS(TAPS_W)) u_gen_step (
        .cur  (data),
        .mode (mode),
        .nxt  (gen_next_c)
    );

    ddr2_if_ex_pattern_step #(.WIDTH(WIDTH), .TAPS(TAPS_W)) u_chk_step (
        .cur  (expected),
        .mode (mode),
        .nxt  (chk_next_c)
    );

    // Generator: enable > load > pause > step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= SEED_W;
        end else if (!enable) begin
            data <= init_c;
        end else if (load) begin
            data <= ldata;
        end else if (!pause) begin
            data <= gen_next_c;
        end
    end

    // Checker: compare against the locally regenerated pattern, counters saturate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expected      <= SEED_W;
            err_flag      <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            vld_cnt       <= '0;
        end else if (!chk_en) begin
            expected      <= init_c;
            err_flag      <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            vld_cnt       <= '0;
        end else if (chk_valid) begin
            expected <= chk_next_c;
            if (vld_cnt != '1) begin
                vld_cnt <= vld_cnt + CNTW'(1);
            end
            if (mismatch_c) begin
                err_flag <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNTW'(1);
                end
                if (!err_flag) begin
                    first_err_idx <= vld_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr2_if_ex_lfsr_genchk.sv
// Directed bench for the pattern generator/checker: sequences, priority, checker errors, saturation, reset.
module tb_ddr2_if_ex_lfsr_genchk;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        pause;
    logic        load;
    logic [7:0]  ldata;
    logic [1:0]  mode;
    logic        chk_en;
    logic        chk_valid;
    logic [7:0]  chk_data;

    logic [7:0]  data;
    logic        err_flag;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;

    logic [7:0]  data4;
    logic        err_flag4;
    logic [3:0]  err_cnt4;
    logic [3:0]  first_err_idx4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ddr2_if_ex_lfsr_genchk dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .pause         (pause),
        .load          (load),
        .ldata         (ldata),
        .mode          (mode),
        .data          (data),
        .chk_en        (chk_en),
        .chk_valid     (chk_valid),
        .chk_data      (chk_data),
        .err_flag      (err_flag),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    ddr2_if_ex_lfsr_genchk #(.CNTW(4)) dut4 (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .pause         (pause),
        .load          (load),
        .ldata         (ldata),
        .mode          (mode),
        .data          (data4),
        .chk_en        (chk_en),
        .chk_valid     (chk_valid),
        .chk_data      (chk_data),
        .err_flag      (err_flag4),
        .err_cnt       (err_cnt4),
        .first_err_idx (first_err_idx4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reinitialise generator and checker together so the streams are aligned.
    task automatic resync();
        chk_valid = 1'b0;
        enable    = 1'b0;
        chk_en    = 1'b0;
        tick();
        enable    = 1'b1;
        chk_en    = 1'b1;
    endtask

    initial begin
        logic [7:0] w;

        reset_n   = 1'b1;
        enable    = 1'b1;
        pause     = 1'b0;
        load      = 1'b0;
        ldata     = 8'h00;
        mode      = 2'd0;
        chk_en    = 1'b1;
        chk_valid = 1'b0;
        chk_data  = 8'h00;
        #2 reset_n = 1'b0;
        #10;

        check("rst_data",    32'(data), 32'h20);
        check("rst_flag",    32'(err_flag), 32'h0);
        check("rst_cnt",     32'(err_cnt), 32'h0);
        check("rst_first",   32'(first_err_idx), 32'h0);

        // LFSR sequence from seed
        tick();
        reset_n = 1'b1;
        check("lfsr0", 32'(data), 32'h20);
        tick(); check("lfsr1", 32'(data), 32'h40);
        tick(); check("lfsr2", 32'(data), 32'h80);
        tick(); check("lfsr3", 32'(data), 32'h1D);
        tick(); check("lfsr4", 32'(data), 32'h3A);

        // Walking one
        mode = 2'd1; enable = 1'b0;
        tick(); check("walk_init", 32'(data), 32'h01);
        enable = 1'b1;
        w = 8'h01;
        for (int i = 0; i < 8; i++) begin
            tick();
            w = {w[6:0], w[7]};
            check("walk", 32'(data), 32'(w));
        end

        // Alternate
        mode = 2'd2; enable = 1'b0;
        tick(); check("alt_init", 32'(data), 32'h20);
        enable = 1'b1;
        tick(); check("alt1", 32'(data), 32'hDF);
        tick(); check("alt2", 32'(data), 32'h20);

        // Mode change applies new rule without re-init
        mode = 2'd0;
        tick(); check("mode_switch", 32'(data), 32'h40);

        // Reserved mode behaves as LFSR
        mode = 2'd3; enable = 1'b0;
        tick(); check("rsvd_init", 32'(data), 32'h20);
        enable = 1'b1;
        tick(); tick(); tick();
        check("rsvd_step", 32'(data), 32'h1D);

        // Load / pause / enable priority
        mode = 2'd0; load = 1'b1; pause = 1'b1; ldata = 8'hA5;
        tick(); check("load", 32'(data), 32'hA5);
        load = 1'b0;
        tick(); check("pause_hold", 32'(data), 32'hA5);
        enable = 1'b0; load = 1'b1;
        tick(); check("en_over_load", 32'(data), 32'h20);
        load = 1'b0; pause = 1'b0; enable = 1'b1;
        check("chk_ignores_gen", 32'(err_cnt), 32'h0);

        // Clean loopback for 1000 words
        resync();
        chk_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            chk_data = data;
            tick();
        end
        chk_valid = 1'b0;
        check("clean_flag",  32'(err_flag), 32'h0);
        check("clean_cnt",   32'(err_cnt), 32'h0);
        check("clean_first", 32'(first_err_idx), 32'h0);

        // Corrupt 5th and 9th valid words
        resync();
        chk_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            chk_data = (i == 4 || i == 8) ? (data ^ 8'h01) : data;
            tick();
            if (i == 3) check("pre_err_flag", 32'(err_flag), 32'h0);
            if (i == 4) check("lat1_err_flag", 32'(err_flag), 32'h1);
        end
        chk_valid = 1'b0;
        check("err2_cnt",    32'(err_cnt), 32'h2);
        check("err2_first",  32'(first_err_idx), 32'h4);
        check("err2_flag",   32'(err_flag), 32'h1);
        check("err2_cnt4",   32'(err_cnt4), 32'h2);
        chk_en = 1'b0;
        tick();
        chk_en = 1'b1;
        check("clr_flag",  32'(err_flag), 32'h0);
        check("clr_cnt",   32'(err_cnt), 32'h0);
        check("clr_first", 32'(first_err_idx), 32'h0);

        // 20 mismatches: 4-bit counter saturates
        resync();
        chk_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk_data = ~data;
            tick();
        end
        chk_valid = 1'b0;
        check("sat_cnt4",   32'(err_cnt4), 32'hF);
        check("sat_flag4",  32'(err_flag4), 32'h1);
        check("sat_first4", 32'(first_err_idx4), 32'h0);
        check("nosat_cnt",  32'(err_cnt), 32'd20);

        // Valid-word counter saturation feeds first_err_idx
        resync();
        chk_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            chk_data = (i == 20) ? (data ^ 8'h80) : data;
            tick();
        end
        check("vsat_first4", 32'(first_err_idx4), 32'hF);
        check("vsat_first",  32'(first_err_idx), 32'd20);
        check("vsat_cnt4",   32'(err_cnt4), 32'h1);

        // Asynchronous reset mid-stream, mode independent
        for (int i = 0; i < 3; i++) begin
            chk_data = ~data;
            tick();
        end
        #2;
        reset_n = 1'b0;
        mode    = 2'd1;
        #1;
        check("arst_data",   32'(data), 32'h20);
        check("arst_flag",   32'(err_flag), 32'h0);
        check("arst_cnt",    32'(err_cnt), 32'h0);
        check("arst_first",  32'(first_err_idx), 32'h0);
        check("arst_cnt4",   32'(err_cnt4), 32'h0);
        check("arst_first4", 32'(first_err_idx4), 32'h0);
        chk_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_walk", 32'(data), 32'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr2_if_ex_lfsr_genchk.md
DDR2_IF_EX_LFSR_GENCHK -- requirements
Module: ddr2_if_ex_lfsr_genchk

Interface
REQ-001 Parameter WIDTH, 8, data and pattern width in bits, legal range 4..64.
REQ-002 Parameter TAPS, 8'h1C (zero-extended to WIDTH), Galois feedback mask; bit i set means feedback XORs into bit i, bit 0 ignored.
REQ-003 Parameter SEED, 32, initial pattern value (low WIDTH bits); shall be non-zero.
REQ-004 Parameter CNTW, 16, error-counter width in bits.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 enable  input  1  low holds the generator at its mode init value.
REQ-008 pause  input  1  high freezes the generator.
REQ-009 load  input  1  high loads ldata into the generator.
REQ-010 ldata  input  WIDTH  load value.
REQ-011 mode  input  2  0=LFSR, 1=walking-one, 2=alternate SEED/~SEED, 3=reserved (treated as 0).
REQ-012 data  output  WIDTH  current generator value, driven directly from register.
REQ-013 chk_en  input  1  low clears and holds the checker.
REQ-014 chk_valid  input  1  chk_data is presented this cycle.
REQ-015 chk_data  input  WIDTH  read-back word to compare.
REQ-016 err_flag  output  1  sticky: at least one mismatch since checker clear.
REQ-017 err_cnt  output  CNTW  saturating mismatch count.
REQ-018 first_err_idx  output  CNTW  number of valid words preceding the first mismatch; saturating.

Function
REQ-019 LFSR step shall be: next[0]=cur[W-1]; next[i]=cur[i-1] ^ (TAPS[i] & cur[W-1]) for i>=1.
REQ-020 Walking-one step shall rotate left by one; alternate step shall be bitwise invert.
REQ-021 Init value shall be SEED for modes 0/2/3 and 1 for mode 1.
REQ-022 Generator priority per cycle: enable low -> init(mode); else load -> ldata; else pause -> hold; else step(mode).
REQ-023 Mode change with enable high shall apply the new step rule to the current value next cycle, with no re-init.
REQ-024 Checker shall hold an expected-value register using the same step rule and mode.
REQ-025 chk_en low shall set expected to init(mode) and clear err_flag, err_cnt, and first_err_idx, plus the internal valid-word counter.
REQ-026 On chk_valid with chk_en high, the checker shall compare chk_data with expected, then step expected; result appears on outputs the following cycle (latency 1).
REQ-027 On mismatch, err_cnt shall increment unless already all-ones, and err_flag shall set.
REQ-028 On the first mismatch only, first_err_idx shall capture the valid-word counter; the counter shall saturate at all-ones.
REQ-029 The checker shall ignore pause and load; the generator shall ignore chk_* inputs.

Reset
REQ-030 reset_n low shall set data=SEED, expected=SEED, err_flag=0, err_cnt=0, first_err_idx=0, and valid-word counter=0, independent of mode.
REQ-031 Reset deassertion shall take effect on the next rising clk; no output shall glitch other than the asynchronous assertion.

Structure
REQ-032 Mode encodings (LFSR, WALK, ALT) shall be constants in the shared DDR2_IF_ex package.
REQ-033 The step function shall be one sub-module, ddr2_if_ex_pattern_step (combinational: cur, mode -> next), instantiated twice (generator and checker).

Verification
REQ-034 WIDTH=8, SEED=0x20, TAPS=0x1C, mode 0, enable high -> data sequence 0x20, 0x40, 0x80, 0x1D on consecutive cycles.
REQ-035 Mode 1, enable low then high -> data 0x01, 0x02, 0x04 ... 0x80, 0x01; mode 2 -> 0x20, 0xDF, 0x20.
REQ-036 Cycle with load=1, pause=1, ldata=0xA5 -> data=0xA5; next cycle with pause=1 -> 0xA5 held; enable low with load high -> 0x20.
REQ-037 Loop data into chk_data with chk_valid every cycle for 1000 cycles -> err_flag=0, err_cnt=0.
REQ-038 Corrupt the 5th and 9th valid words (XOR 0x01) -> err_cnt=2, first_err_idx=4, err_flag=1; chk_en low for one cycle -> all three clear.
REQ-039 CNTW=4 with 20 forced mismatches -> err_cnt saturates at 15; reset_n pulse mid-stream -> all outputs return to reset values asynchronously.
